// File: rtl/mem_rd_checker_if.sv
// mem_rd_checker_if: RAM tap signals, checker controls and checker results
// shared between the memory-interface environment and the read checker.
interface mem_rd_checker_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
);

  // RAM write port tap
  logic                  wr_cs;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // RAM read port tap
  logic                  rd_cs;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  ecccorr;
  logic                  eccderr;

  // Checker controls
  logic                  chk_en;
  logic                  clr;

  // Per-read response
  logic                  rsp_valid;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  mismatch;

  // Statistics
  logic [CNT_WIDTH-1:0]  rd_cnt;
  logic [CNT_WIDTH-1:0]  err_cnt;
  logic [CNT_WIDTH-1:0]  corr_cnt;
  logic [CNT_WIDTH-1:0]  derr_cnt;
  logic [CNT_WIDTH-1:0]  skip_cnt;

  // First-error capture
  logic                  first_err_valid;
  logic [ADDR_WIDTH-1:0] first_err_addr;
  logic [DATA_WIDTH-1:0] first_err_exp;
  logic [DATA_WIDTH-1:0] first_err_act;

  // Environment side: drives the taps and controls, observes results
  modport master (
    output wr_cs, wr_addr, wr_data,
    output rd_cs, rd_addr, rd_data, ecccorr, eccderr,
    output chk_en, clr,
    input  rsp_valid, rsp_addr, rsp_data, mismatch,
    input  rd_cnt, err_cnt, corr_cnt, derr_cnt, skip_cnt,
    input  first_err_valid, first_err_addr, first_err_exp, first_err_act
  );

  // Checker side
  modport slave (
    input  wr_cs, wr_addr, wr_data,
    input  rd_cs, rd_addr, rd_data, ecccorr, eccderr,
    input  chk_en, clr,
    output rsp_valid, rsp_addr, rsp_data, mismatch,
    output rd_cnt, err_cnt, corr_cnt, derr_cnt, skip_cnt,
    output first_err_valid, first_err_addr, first_err_exp, first_err_act
  );

endinterface

// File: rtl/mem_rd_checker.sv
// mem_rd_checker: passive read-data checker for a dual-port RAM. Shadows every
// write, captures the expected data for each read, aligns it with the RAM's
// returned data RD_LATENCY+1 cycles later and compares. Produces per-read
// responses, mismatch pulses, saturating statistics and a first-error capture.
module mem_rd_checker #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input logic             clk,
  input logic             rst_n,
  mem_rd_checker_if.slave bus
);

  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam int unsigned PIPE_N = RD_LATENCY + 1;

  // Shadow store
  logic [DEPTH-1:0]                   r_shadow_vld;
  logic [DATA_WIDTH-1:0]              r_shadow_mem [DEPTH];

  // Read-alignment pipeline; stage 0 is loaded on the issue edge
  logic [PIPE_N-1:0]                  r_pipe_vld;
  logic [PIPE_N-1:0]                  r_pipe_expv;
  logic [PIPE_N-1:0][ADDR_WIDTH-1:0]  r_pipe_addr;
  logic [PIPE_N-1:0][DATA_WIDTH-1:0]  r_pipe_exp;

  // Registered outputs
  logic                  r_rsp_valid;
  logic [ADDR_WIDTH-1:0] r_rsp_addr;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_mismatch;
  logic [CNT_WIDTH-1:0]  r_rd_cnt;
  logic [CNT_WIDTH-1:0]  r_err_cnt;
  logic [CNT_WIDTH-1:0]  r_corr_cnt;
  logic [CNT_WIDTH-1:0]  r_derr_cnt;
  logic [CNT_WIDTH-1:0]  r_skip_cnt;
  logic                  r_fe_valid;
  logic [ADDR_WIDTH-1:0] r_fe_addr;
  logic [DATA_WIDTH-1:0] r_fe_exp;
  logic [DATA_WIDTH-1:0] r_fe_act;

  logic w_wr_en;
  logic w_rd_en;
  logic w_collide;
  logic w_issue_expv;
  logic w_done;
  logic w_cmp;
  logic w_fail;
  logic w_corr;
  logic w_derr;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Issue/completion decode; a clr edge neither records writes nor issues reads
  always_comb begin
    w_wr_en      = bus.wr_cs & ~bus.clr;
    w_rd_en      = bus.rd_cs & ~bus.clr;
    w_collide    = bus.wr_cs & (bus.wr_addr == bus.rd_addr);
    w_issue_expv = r_shadow_vld[bus.rd_addr] & ~w_collide;
    w_done       = r_pipe_vld[RD_LATENCY];
    w_cmp        = w_done & bus.chk_en & r_pipe_expv[RD_LATENCY];
    w_fail       = w_cmp & (bus.rd_data !== r_pipe_exp[RD_LATENCY]);
    w_corr       = (bus.ecccorr === 1'b1);
    w_derr       = (bus.eccderr === 1'b1);
  end

  // Shadow valid bits: set on write, cleared by reset or clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_vld <= '0;
    end else if (bus.clr) begin
      r_shadow_vld <= '0;
    end else if (w_wr_en) begin
      r_shadow_vld[bus.wr_addr] <= 1'b1;
    end
  end

  // Shadow data array; contents are qualified by the valid bits
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_shadow_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Alignment pipeline: expected data read before this edge's write lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vld  <= '0;
      r_pipe_expv <= '0;
      r_pipe_addr <= '0;
      r_pipe_exp  <= '0;
    end else if (bus.clr) begin
      r_pipe_vld  <= '0;
      r_pipe_expv <= '0;
    end else begin
      r_pipe_vld  <= {r_pipe_vld[PIPE_N-2:0], w_rd_en};
      r_pipe_expv <= {r_pipe_expv[PIPE_N-2:0], w_issue_expv};
      r_pipe_addr <= {r_pipe_addr[PIPE_N-2:0], bus.rd_addr};
      r_pipe_exp  <= {r_pipe_exp[PIPE_N-2:0], r_shadow_mem[bus.rd_addr]};
    end
  end

  // Completion: response, compare result, statistics and first-error capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_data  <= '0;
      r_mismatch  <= 1'b0;
      r_rd_cnt    <= '0;
      r_err_cnt   <= '0;
      r_corr_cnt  <= '0;
      r_derr_cnt  <= '0;
      r_skip_cnt  <= '0;
      r_fe_valid  <= 1'b0;
      r_fe_addr   <= '0;
      r_fe_exp    <= '0;
      r_fe_act    <= '0;
    end else if (bus.clr) begin
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_data  <= '0;
      r_mismatch  <= 1'b0;
      r_rd_cnt    <= '0;
      r_err_cnt   <= '0;
      r_corr_cnt  <= '0;
      r_derr_cnt  <= '0;
      r_skip_cnt  <= '0;
      r_fe_valid  <= 1'b0;
      r_fe_addr   <= '0;
      r_fe_exp    <= '0;
      r_fe_act    <= '0;
    end else begin
      r_rsp_valid <= w_done;
      r_mismatch  <= w_fail;
      if (w_done) begin
        r_rsp_addr <= r_pipe_addr[RD_LATENCY];
        r_rsp_data <= bus.rd_data;
        r_rd_cnt   <= sat_inc(r_rd_cnt);
        if (w_corr) begin
          r_corr_cnt <= sat_inc(r_corr_cnt);
        end
        if (w_derr) begin
          r_derr_cnt <= sat_inc(r_derr_cnt);
        end
        if (!w_cmp) begin
          r_skip_cnt <= sat_inc(r_skip_cnt);
        end
        if (w_fail) begin
          r_err_cnt <= sat_inc(r_err_cnt);
          if (!r_fe_valid) begin
            r_fe_valid <= 1'b1;
            r_fe_addr  <= r_pipe_addr[RD_LATENCY];
            r_fe_exp   <= r_pipe_exp[RD_LATENCY];
            r_fe_act   <= bus.rd_data;
          end
        end
      end
    end
  end

  assign bus.rsp_valid       = r_rsp_valid;
  assign bus.rsp_addr        = r_rsp_addr;
  assign bus.rsp_data        = r_rsp_data;
  assign bus.mismatch        = r_mismatch;
  assign bus.rd_cnt          = r_rd_cnt;
  assign bus.err_cnt         = r_err_cnt;
  assign bus.corr_cnt        = r_corr_cnt;
  assign bus.derr_cnt        = r_derr_cnt;
  assign bus.skip_cnt        = r_skip_cnt;
  assign bus.first_err_valid = r_fe_valid;
  assign bus.first_err_addr  = r_fe_addr;
  assign bus.first_err_exp   = r_fe_exp;
  assign bus.first_err_act   = r_fe_act;

endmodule

// File: tb/tb_mem_rd_checker.sv
// Bench for mem_rd_checker: a behavioural RAM drives read data after the read
// latency, and a scoreboard of outstanding reads predicts every checker output.
module tb_mem_rd_checker;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned LAT   = 3;
  localparam int unsigned CW    = 8;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int          CMAX  = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_rd_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  mem_rd_checker #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT), .CNT_WIDTH(CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct { int unsigned due; bit [DW-1:0] data; bit corr; bit derr; } ram_rsp_t;
  typedef struct { int unsigned due; bit [AW-1:0] addr; bit [DW-1:0] exp; bit expv; } exp_t;

  // RAM model (never cleared by the checker's clr or reset)
  bit [DW-1:0] ram_mem [DEPTH];
  ram_rsp_t    ram_q[$];
  bit          inj_bad, inj_corr, inj_derr;
  int          rnd_pct;

  // Checker reference model
  bit          sh_vld  [DEPTH];
  bit [DW-1:0] sh_data [DEPTH];
  exp_t        exp_q[$];
  bit          m_rsp_valid, m_mismatch;
  bit [AW-1:0] m_rsp_addr;
  bit [DW-1:0] m_rsp_data;
  int          m_rd, m_err, m_corr, m_derr, m_skip;
  bit          m_fe_v;
  bit [AW-1:0] m_fe_addr;
  bit [DW-1:0] m_fe_exp, m_fe_act;

  int unsigned cyc;
  int          total, bad, rsp_seen, s;
  bit          g_en = 1'b1;

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_rsp_valid = 1'b0; m_mismatch = 1'b0;
    m_rd = 0; m_err = 0; m_corr = 0; m_derr = 0; m_skip = 0;
    m_fe_v = 1'b0; m_fe_addr = '0; m_fe_exp = '0; m_fe_act = '0;
    foreach (sh_vld[i]) sh_vld[i] = 1'b0;
  endtask

  task automatic check_outputs();
    if (bus.rsp_valid === 1'b1) rsp_seen++;
    check("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp_valid));
    check("mismatch",  32'(bus.mismatch),  32'(m_mismatch));
    if (m_rsp_valid) begin
      check("rsp_addr", 32'(bus.rsp_addr), 32'(m_rsp_addr));
      check("rsp_data", 32'(bus.rsp_data), 32'(m_rsp_data));
    end
    check("rd_cnt",   32'(bus.rd_cnt),   32'(m_rd));
    check("err_cnt",  32'(bus.err_cnt),  32'(m_err));
    check("corr_cnt", 32'(bus.corr_cnt), 32'(m_corr));
    check("derr_cnt", 32'(bus.derr_cnt), 32'(m_derr));
    check("skip_cnt", 32'(bus.skip_cnt), 32'(m_skip));
    check("fe_valid", 32'(bus.first_err_valid), 32'(m_fe_v));
    if (m_fe_v) begin
      check("fe_addr", 32'(bus.first_err_addr), 32'(m_fe_addr));
      check("fe_exp",  32'(bus.first_err_exp),  32'(m_fe_exp));
      check("fe_act",  32'(bus.first_err_act),  32'(m_fe_act));
    end
  endtask

  // One clock: drive inputs at the negedge, step models at the posedge, check
  task automatic tick(input bit wr, input bit [AW-1:0] wa, input bit [DW-1:0] wd,
                      input bit rd, input bit [AW-1:0] ra, input bit cl);
    int unsigned e;
    ram_rsp_t    r;
    exp_t        x;
    bit          b;
    e = cyc + 1;
    if (ram_q.size() > 0 && ram_q[0].due == e) begin
      r = ram_q.pop_front();
      bus.rd_data = r.data; bus.ecccorr = r.corr; bus.eccderr = r.derr;
    end else begin
      bus.rd_data = DW'($urandom); bus.ecccorr = 1'($urandom); bus.eccderr = 1'($urandom);
    end
    bus.wr_cs = wr; bus.wr_addr = wa; bus.wr_data = wd;
    bus.rd_cs = rd; bus.rd_addr = ra;
    bus.chk_en = g_en; bus.clr = cl;
    @(posedge clk);
    cyc = e;
    if (rd) begin
      b      = inj_bad || ($urandom_range(99) < rnd_pct);
      r.due  = e + LAT + 1;
      r.data = b ? ~ram_mem[ra] : ram_mem[ra];
      r.corr = inj_corr || ($urandom_range(99) < rnd_pct);
      r.derr = inj_derr || ($urandom_range(99) < rnd_pct);
      ram_q.push_back(r);
    end
    if (wr) ram_mem[wa] = wd;
    m_rsp_valid = 1'b0;
    m_mismatch  = 1'b0;
    if (!rst_n) begin
      model_clear();
    end else if (cl) begin
      model_clear();
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due == e) begin
        x = exp_q.pop_front();
        m_rsp_valid = 1'b1; m_rsp_addr = x.addr; m_rsp_data = bus.rd_data;
        m_rd = sat(m_rd);
        if (bus.ecccorr) m_corr = sat(m_corr);
        if (bus.eccderr) m_derr = sat(m_derr);
        if (g_en && x.expv) begin
          if (bus.rd_data != x.exp) begin
            m_mismatch = 1'b1;
            m_err = sat(m_err);
            if (!m_fe_v) begin
              m_fe_v = 1'b1; m_fe_addr = x.addr; m_fe_exp = x.exp; m_fe_act = bus.rd_data;
            end
          end
        end else begin
          m_skip = sat(m_skip);
        end
      end
      if (rd) begin
        x.due = e + LAT + 1; x.addr = ra; x.exp = sh_data[ra];
        x.expv = sh_vld[ra] && !(wr && wa == ra);
        exp_q.push_back(x);
      end
      if (wr) begin
        sh_vld[wa] = 1'b1; sh_data[wa] = wd;
      end
    end
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic rd(input bit [AW-1:0] a);
    tick(1'b0, '0, '0, 1'b1, a, 1'b0);
  endtask

  // Asynchronous reset assertion mid-cycle, synchronous release at a negedge
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_outputs();
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.wr_cs = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_cs = 1'b0; bus.rd_addr = '0; bus.rd_data = '0;
    bus.ecccorr = 1'b0; bus.eccderr = 1'b0;
    bus.chk_en = 1'b1; bus.clr = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Basic pass, with exact completion timing
    tick(1'b1, 8'h10, 8'h5A, 1'b0, '0, 1'b0);
    idle(2);
    rd(8'h10);
    idle(LAT);
    idle(1);
    check("basic_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("basic_rsp_data",  32'(bus.rsp_data),  32'h5A);
    idle(1);
    check("basic_rd_cnt",  32'(bus.rd_cnt),  32'd1);
    check("basic_err_cnt", 32'(bus.err_cnt), 32'd0);

    // Corrupted read data and first-error capture
    inj_bad = 1'b1; rd(8'h10); inj_bad = 1'b0;
    idle(LAT + 1);
    check("bad1_err_cnt", 32'(bus.err_cnt), 32'd1);
    check("bad1_fe_valid", 32'(bus.first_err_valid), 32'd1);
    check("bad1_fe_addr", 32'(bus.first_err_addr), 32'h10);
    check("bad1_fe_exp",  32'(bus.first_err_exp),  32'h5A);
    check("bad1_fe_act",  32'(bus.first_err_act),  32'hA5);
    inj_bad = 1'b1; rd(8'h10); inj_bad = 1'b0;
    idle(LAT + 1);
    check("bad2_err_cnt", 32'(bus.err_cnt), 32'd2);
    check("bad2_fe_act",  32'(bus.first_err_act), 32'hA5);

    // Skipped compares: unwritten, same-edge write/read, chk_en low
    rd(8'h33);
    idle(LAT + 1);
    check("skip_unwritten", 32'(bus.skip_cnt), 32'd1);
    tick(1'b1, 8'h20, 8'h77, 1'b1, 8'h20, 1'b0);
    idle(LAT + 1);
    check("skip_collide", 32'(bus.skip_cnt), 32'd2);
    g_en = 1'b0; rd(8'h10); idle(LAT + 1); g_en = 1'b1;
    check("skip_chk_en", 32'(bus.skip_cnt), 32'd3);

    // ECC flags on correct data
    inj_corr = 1'b1; inj_derr = 1'b1;
    rd(8'h10); rd(8'h10);
    inj_corr = 1'b0; inj_derr = 1'b0;
    idle(LAT + 1);
    check("ecc_corr_cnt", 32'(bus.corr_cnt), 32'd2);
    check("ecc_derr_cnt", 32'(bus.derr_cnt), 32'd2);
    check("ecc_err_cnt",  32'(bus.err_cnt),  32'd2);

    // clr flush with two reads in flight
    tick(1'b1, 8'h40, 8'h11, 1'b0, '0, 1'b0);
    s = rsp_seen;
    rd(8'h40); rd(8'h40);
    tick(1'b0, '0, '0, 1'b0, '0, 1'b1);
    idle(LAT + 2);
    check("clr_no_rsp", 32'(rsp_seen - s), 32'd0);
    check("clr_rd_cnt", 32'(bus.rd_cnt), 32'd0);
    check("clr_fe_valid", 32'(bus.first_err_valid), 32'd0);
    rd(8'h40);
    idle(LAT + 1);
    check("clr_skip_after", 32'(bus.skip_cnt), 32'd1);

    // Reset flush with two reads in flight
    tick(1'b1, 8'h41, 8'h22, 1'b0, '0, 1'b0);
    s = rsp_seen;
    rd(8'h41); rd(8'h41);
    do_reset();
    idle(LAT + 2);
    check("rst_no_rsp", 32'(rsp_seen - s), 32'd0);
    check("rst_rd_cnt", 32'(bus.rd_cnt), 32'd0);
    rd(8'h41);
    idle(LAT + 1);
    check("rst_skip_after", 32'(bus.skip_cnt), 32'd1);

    // Streaming: full-array writes then back-to-back reads
    for (int i = 0; i < 256; i++) tick(1'b1, AW'(i), DW'($urandom), 1'b0, '0, 1'b0);
    s = rsp_seen;
    for (int i = 0; i < 256; i++) rd(AW'(i));
    idle(LAT + 1);
    check("stream_pulses", 32'(rsp_seen - s), 32'd256);
    check("stream_err_cnt", 32'(bus.err_cnt), 32'd0);
    check("stream_rd_sat", 32'(bus.rd_cnt), 32'(CMAX));

    // Error counter saturation
    inj_bad = 1'b1;
    for (int i = 0; i < 270; i++) rd(8'h10);
    inj_bad = 1'b0;
    idle(LAT + 1);
    check("err_sat", 32'(bus.err_cnt), 32'(CMAX));
    check("err_sat_fe_addr", 32'(bus.first_err_addr), 32'h10);

    // Randomised traffic over a small address window
    rnd_pct = 20;
    for (int i = 0; i < 1500; i++) begin
      g_en = ($urandom_range(9) != 0);
      if (i == 750) do_reset();
      tick(1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom),
           1'($urandom_range(1)), AW'($urandom_range(15)), ($urandom_range(199) == 0));
    end
    rnd_pct = 0;
    g_en = 1'b1;
    idle(LAT + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
